// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Holds the FSM state enum, opcode constants and datapath select encodings.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
    MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BEQ   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_BNE   = 2'b11;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // States that hold a memory access open until mem_ready.
  function automatic logic is_wait_state(state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Opcode/handshake inputs and datapath control outputs of the control unit.
// master = the controller, slave = the datapath/memory side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             branch_ne;
  logic [1:0]       pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             reg_write;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             trap;
  logic             trap_cause;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
           mem_write, ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a,
           alu_src_b, alu_op, trap, trap_cause, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
           mem_write, ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a,
           alu_src_b, alu_op, trap, trap_cause, retired
  );
endinterface

// File: rtl/multicycle_control_mem_watchdog.sv
// Counts consecutive cycles waiting on mem_ready and flags expiry at TIMEOUT.
// Expiry is combinational so a ready arriving on the limit cycle still wins.
module multicycle_control_mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic expired
);
  localparam int  CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic ENABLED = (TIMEOUT > 0);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [CW-1:0] count_inc;
  logic          stalled;

  assign stalled   = waiting && !mem_ready;
  assign count_inc = count_reg + CW'(1);

  // Any cycle not stalled clears the count, which covers every entry to a wait state.
  always_comb begin
    count_next = '0;
    if (stalled) count_next = count_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) count_reg <= '0;
    else       count_reg <= count_next;
  end

  assign expired = ENABLED && stalled && (count_inc == CW'(TIMEOUT));
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// traps on illegal opcodes or memory timeouts and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 16,
  parameter int ENABLE_JUMP = 1
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);
  state_t           state_reg, state_next;
  logic [5:0]       op_q_reg, op_q_next;
  logic             cause_reg, cause_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;
  logic             expired;
  ctrl_t            ctrl;

  multicycle_control_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .waiting   (is_wait_state(state_reg)),
    .mem_ready (bus.mem_ready),
    .expired   (expired)
  );

  always_comb begin
    state_next = state_reg;
    op_q_next  = op_q_reg;
    cause_next = cause_reg;
    retire     = 1'b0;
    ctrl       = '0;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_next = DECODE;
        else if (expired) begin
          state_next = TRAP;
          cause_next = 1'b1;
        end
      end
      DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        op_q_next      = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:     state_next = EXEC_R;
          OP_ADDI:      state_next = EXEC_I;
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_J: begin
            state_next = (ENABLE_JUMP != 0) ? JUMP : TRAP;
            if (ENABLE_JUMP == 0) cause_next = 1'b0;
          end
          default: begin
            state_next = TRAP;
            cause_next = 1'b0;
          end
        endcase
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_FUNCT;
        state_next     = WB_R;
      end
      WB_R: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_next     = FETCH;
        retire         = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        if (state_reg == EXEC_I) state_next = WB_I;
        else                     state_next = (op_q_reg == OP_SW) ? MEM_WR : MEM_RD;
      end
      WB_I: begin
        ctrl.reg_write = 1'b1;
        state_next     = FETCH;
        retire         = 1'b1;
      end
      MEM_RD, MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (state_reg == MEM_RD);
        ctrl.mem_write = (state_reg == MEM_WR);
        if (bus.mem_ready) begin
          state_next = (state_reg == MEM_RD) ? WB_MEM : FETCH;
          retire     = (state_reg == MEM_WR);
        end else if (expired) begin
          state_next = TRAP;
          cause_next = 1'b1;
        end
      end
      WB_MEM: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        state_next      = FETCH;
        retire          = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.branch_ne     = (op_q_reg == OP_BNE);
        ctrl.alu_op        = (op_q_reg == OP_BNE) ? ALU_BNE : ALU_BEQ;
        state_next         = FETCH;
        retire             = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
        state_next     = FETCH;
        retire         = 1'b1;
      end
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_q_reg    <= '0;
      cause_reg   <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      op_q_reg  <= op_q_next;
      cause_reg <= cause_next;
      if (retire) retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.branch_ne     = ctrl.branch_ne;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.trap          = (state_reg == TRAP);
  assign bus.trap_cause    = cause_reg;
  assign bus.retired       = retired_reg;
endmodule

// File: tb/tb_multicycle_control.sv
// Vector bench: instance a (CNT_W=3, TIMEOUT=4, jump on) via a table,
// instance b (defaults, TIMEOUT=0, jump off) via a hand-written sequence.
module tb_multicycle_control;

  typedef enum int {
    L_IDLE, L_FETCH_W, L_FETCH_R, L_DECODE, L_EXEC_R, L_WB_R, L_EXEC_I, L_WB_I,
    L_MEM_ADDR, L_MEM_RD, L_WB_MEM, L_MEM_WR, L_BR_EQ, L_BR_NE, L_JUMP,
    L_TRAP0, L_TRAP1
  } lbl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    lbl_t       lbl;
    logic [2:0] ret;
  } vec_t;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(3))  bus_a ();
  multicycle_control_if #(.CNT_W(32)) bus_b ();

  multicycle_control #(.CNT_W(3), .TIMEOUT(4), .ENABLE_JUMP(1)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a.master));
  multicycle_control #(.CNT_W(32), .TIMEOUT(0), .ENABLE_JUMP(0)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b.master));

  logic [18:0] act_a, act_b;
  assign act_a = {bus_a.pc_write, bus_a.pc_write_cond, bus_a.branch_ne, bus_a.pc_source,
                  bus_a.i_or_d, bus_a.mem_read, bus_a.mem_write, bus_a.ir_write,
                  bus_a.reg_dst, bus_a.reg_write, bus_a.mem_to_reg, bus_a.alu_src_a,
                  bus_a.alu_src_b, bus_a.alu_op, bus_a.trap, bus_a.trap_cause};
  assign act_b = {bus_b.pc_write, bus_b.pc_write_cond, bus_b.branch_ne, bus_b.pc_source,
                  bus_b.i_or_d, bus_b.mem_read, bus_b.mem_write, bus_b.ir_write,
                  bus_b.reg_dst, bus_b.reg_write, bus_b.mem_to_reg, bus_b.alu_src_a,
                  bus_b.alu_src_b, bus_b.alu_op, bus_b.trap, bus_b.trap_cause};

  // Expected control word per observed step, written out from the state table.
  function automatic logic [18:0] exp_ctrl(lbl_t l);
    logic pw, pwc, bne, iod, mr, mw, irw, rd, rw, m2r, asa, tr, tc;
    logic [1:0] pcs, asb, aop;
    {pw, pwc, bne, iod, mr, mw, irw, rd, rw, m2r, asa, tr, tc} = '0;
    {pcs, asb, aop} = '0;
    case (l)
      L_FETCH_W:  begin mr = 1; asb = 2'b01; end
      L_FETCH_R:  begin mr = 1; asb = 2'b01; irw = 1; pw = 1; end
      L_DECODE:   asb = 2'b11;
      L_EXEC_R:   begin asa = 1; aop = 2'b10; end
      L_WB_R:     begin rd = 1; rw = 1; end
      L_EXEC_I:   begin asa = 1; asb = 2'b10; end
      L_WB_I:     rw = 1;
      L_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      L_MEM_RD:   begin mr = 1; iod = 1; end
      L_WB_MEM:   begin m2r = 1; rw = 1; end
      L_MEM_WR:   begin mw = 1; iod = 1; end
      L_BR_EQ:    begin asa = 1; pwc = 1; pcs = 2'b01; aop = 2'b01; end
      L_BR_NE:    begin asa = 1; pwc = 1; pcs = 2'b01; aop = 2'b11; bne = 1; end
      L_JUMP:     begin pw = 1; pcs = 2'b10; end
      L_TRAP0:    tr = 1;
      L_TRAP1:    begin tr = 1; tc = 1; end
      default:    ;
    endcase
    return {pw, pwc, bne, pcs, iod, mr, mw, irw, rd, rw, m2r, asa, asb, aop, tr, tc};
  endfunction

  task automatic check(input string nm, input int idx, input logic [18:0] act,
                       input lbl_t l, input logic [31:0] act_ret, input logic [31:0] ex_ret);
    logic [18:0] ex;
    ex = exp_ctrl(l);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s step %0d ctrl got %b want %b (%s)", nm, idx, act, ex, l.name());
    end
    checks++;
    if (act_ret !== ex_ret) begin
      errors++;
      $display("FAIL %s step %0d retired got %0d want %0d", nm, idx, act_ret, ex_ret);
    end
    $display("%s step %0d %s ctrl=%b retired=%0d", nm, idx, l.name(), act, act_ret);
  endtask

  task automatic add(input logic rst, input int op, input logic rdy, input lbl_t l,
                     input int ret, input int n = 1);
    vec_t v;
    v.rst = rst; v.op = 6'(op); v.rdy = rdy; v.lbl = l; v.ret = 3'(ret);
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic step_b(input logic rst, input int op, input logic rdy, input lbl_t l,
                        input int ret, input int idx);
    @(negedge clk);
    reset_b = rst; bus_b.opcode = 6'(op); bus_b.mem_ready = rdy;
    #1;
    check("b", idx, act_b, l, bus_b.retired, 32'(ret));
  endtask

  initial begin
    // R-type, addi, lw with 3 wait cycles, sw ready on the 4th wait cycle
    add(0, 0, 1, L_IDLE, 0);     add(0, 0, 1, L_FETCH_R, 0);  add(0, 0, 1, L_DECODE, 0);
    add(0, 0, 1, L_EXEC_R, 0);   add(0, 0, 1, L_WB_R, 0);
    add(0, 8, 1, L_FETCH_R, 1);  add(0, 8, 1, L_DECODE, 1);   add(0, 0, 1, L_EXEC_I, 1);
    add(0, 0, 1, L_WB_I, 1);
    add(0, 35, 1, L_FETCH_R, 2); add(0, 35, 1, L_DECODE, 2);  add(0, 43, 1, L_MEM_ADDR, 2);
    add(0, 43, 0, L_MEM_RD, 2, 3); add(0, 43, 1, L_MEM_RD, 2); add(0, 0, 1, L_WB_MEM, 2);
    add(0, 43, 1, L_FETCH_R, 3); add(0, 43, 1, L_DECODE, 3);  add(0, 0, 1, L_MEM_ADDR, 3);
    add(0, 0, 0, L_MEM_WR, 3, 3); add(0, 0, 1, L_MEM_WR, 3);
    // bne, beq, jump, addi wrapping retired 7 -> 0
    add(0, 5, 1, L_FETCH_R, 4);  add(0, 5, 1, L_DECODE, 4);   add(0, 5, 1, L_BR_NE, 4);
    add(0, 4, 1, L_FETCH_R, 5);  add(0, 4, 1, L_DECODE, 5);   add(0, 4, 1, L_BR_EQ, 5);
    add(0, 2, 1, L_FETCH_R, 6);  add(0, 2, 1, L_DECODE, 6);   add(0, 2, 1, L_JUMP, 6);
    add(0, 8, 1, L_FETCH_R, 7);  add(0, 8, 1, L_DECODE, 7);   add(0, 8, 1, L_EXEC_I, 7);
    add(0, 8, 1, L_WB_I, 7);
    // fetch ready on the limit cycle, then illegal opcode trap held until reset
    add(0, 63, 0, L_FETCH_W, 0, 3); add(0, 63, 1, L_FETCH_R, 0); add(0, 63, 1, L_DECODE, 0);
    add(0, 0, 1, L_TRAP0, 0);    add(0, 8, 0, L_TRAP0, 0);    add(1, 0, 1, L_TRAP0, 0);
    // fetch timeout
    add(0, 0, 0, L_IDLE, 0);     add(0, 0, 0, L_FETCH_W, 0, 4);
    add(0, 0, 0, L_TRAP1, 0);    add(0, 0, 1, L_TRAP1, 0);    add(1, 0, 1, L_TRAP1, 0);
    // memory read timeout
    add(0, 0, 1, L_IDLE, 0);     add(0, 35, 1, L_FETCH_R, 0); add(0, 35, 1, L_DECODE, 0);
    add(0, 35, 1, L_MEM_ADDR, 0); add(0, 35, 0, L_MEM_RD, 0, 4);
    add(0, 0, 1, L_TRAP1, 0);    add(1, 0, 1, L_TRAP1, 0);
    // reset while a store is waiting
    add(0, 4, 1, L_IDLE, 0);     add(0, 4, 1, L_FETCH_R, 0);  add(0, 4, 1, L_DECODE, 0);
    add(0, 43, 1, L_BR_EQ, 0);   add(0, 43, 1, L_FETCH_R, 1); add(0, 43, 1, L_DECODE, 1);
    add(0, 43, 1, L_MEM_ADDR, 1); add(0, 43, 0, L_MEM_WR, 1); add(1, 43, 0, L_MEM_WR, 1);
    add(0, 0, 1, L_IDLE, 0);     add(0, 0, 1, L_FETCH_R, 0);

    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.opcode = '0; bus_a.mem_ready = 1'b0;
    bus_b.opcode = '0; bus_b.mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset_a = vecs[i].rst; bus_a.opcode = vecs[i].op; bus_a.mem_ready = vecs[i].rdy;
      #1;
      check("a", i, act_a, vecs[i].lbl, {29'b0, bus_a.retired}, {29'b0, vecs[i].ret});
    end

    // Watchdog disabled: long fetch stall never traps; jump opcode is illegal here
    begin
      int n;
      n = 0;
      step_b(0, 0, 0, L_IDLE, 0, n++);
      for (int k = 0; k < 20; k++) step_b(0, 0, 0, L_FETCH_W, 0, n++);
      step_b(0, 2, 1, L_FETCH_R, 0, n++);
      step_b(0, 2, 1, L_DECODE, 0, n++);
      for (int k = 0; k < 3; k++) step_b(0, 0, 1, L_TRAP0, 0, n++);
      step_b(1, 0, 1, L_TRAP0, 0, n++);
      step_b(0, 0, 1, L_IDLE, 0, n++);
      step_b(0, 0, 1, L_FETCH_R, 0, n++);
      step_b(0, 0, 1, L_DECODE, 0, n++);
      step_b(0, 0, 1, L_EXEC_R, 0, n++);
      step_b(0, 0, 1, L_WB_R, 0, n++);
      step_b(0, 0, 1, L_FETCH_R, 1, n++);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main control decoder.
- An FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives the shared-datapath control lines one step per cycle.
- Adds memory wait-state handshaking, jump support, an illegal-opcode/timeout trap, and a retired-instruction counter.
- Sits between the instruction register (opcode source) and the multi-cycle datapath, memory port and PC logic.

Parameters:
CNT_W, 32, width of the retired-instruction counter.
TIMEOUT, 16, maximum cycles to wait for mem_ready before trapping; 0 disables the watchdog.
ENABLE_JUMP, 1, 1 = opcode 2 is a jump; 0 = opcode 2 is illegal.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
opcode  in  6  instr[31:26] from the instruction register.
mem_ready  in  1  memory completes the current read/write this cycle.
pc_write  out  1  unconditional PC load.
pc_write_cond  out  1  PC load qualified by the branch condition.
branch_ne  out  1  1 = qualify on !zero (bne); 0 = qualify on zero (beq).
pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
ir_write  out  1  load the instruction register.
reg_dst  out  1  1 = rd, 0 = rt.
reg_write  out  1  register file write enable.
mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
alu_src_a  out  1  0 = PC, 1 = register A.
alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
alu_op  out  2  00 add, 01 beq-subtract, 10 funct-decoded, 11 bne-subtract.
trap  out  1  sticky error flag.
trap_cause  out  1  0 = illegal opcode, 1 = memory timeout.
retired  out  CNT_W  count of completed instructions.

Behaviour:
Reset and output model:
- reset high forces state IDLE, retired=0, trap=0, trap_cause=0, timeout counter=0.
- Outputs are Moore outputs of the state register; in IDLE every control output is 0.
- Exceptions: ir_write and pc_write in FETCH also depend on mem_ready.
- Any signal not listed for a state is 0 in that state.

States and transitions:
- IDLE: always -> FETCH on the next cycle.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - mem_ready -> DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; latches opcode into op_q.
  - Next state by opcode: 0 -> EXEC_R; 8 -> EXEC_I; 35 or 43 -> MEM_ADDR; 4 or 5 -> BRANCH; 2 with ENABLE_JUMP=1 -> JUMP.
  - Any other opcode -> TRAP with trap_cause=0.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; -> WB_R.
- WB_R: reg_dst=1, reg_write=1; -> FETCH, retire.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00; -> WB_I.
- WB_I: reg_write=1 (reg_dst=0, mem_to_reg=0); -> FETCH, retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; op_q=35 -> MEM_RD, op_q=43 -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; mem_ready -> WB_MEM, else stay.
- WB_MEM: mem_to_reg=1, reg_write=1; -> FETCH, retire.
- MEM_WR: mem_write=1, i_or_d=1; mem_ready -> FETCH + retire, else stay.
- BRANCH: alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_source=01.
  - op_q=4: alu_op=01, branch_ne=0.
  - op_q=5: alu_op=11, branch_ne=1.
  - -> FETCH, retire.
- JUMP: pc_write=1, pc_source=10; -> FETCH, retire.
- TRAP: trap=1; all other controls 0; absorbing until reset.

Rules:
- "Retire" means retired increments by 1 on the transition edge; it wraps modulo 2^CNT_W.
- Watchdog:
  - The counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments on each cycle spent waiting in one of those states with mem_ready=0.
  - When the count reaches TIMEOUT while mem_ready is still 0 -> TRAP with trap_cause=1.
  - mem_ready=1 in the same cycle the limit is reached wins: normal transition, no trap.
- Instruction boundary: opcode is ignored outside DECODE, and changes after DECODE have no effect.
- reset asserted in any state, including mid-wait or TRAP, takes priority over every transition.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, TRAP).
  - opcode constants OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, OP_LW=35, OP_SW=43.
  - alu_op, alu_src_b and pc_source encodings.
- One natural sub-module: mem_watchdog (counter plus expiry compare); everything else stays in one module.

Test Plan:
- Reset, then opcode=0 with mem_ready tied 1 -> states IDLE, FETCH, DECODE, EXEC_R, WB_R; reg_dst=1 and reg_write=1 in cycle 5; retired=1.
- lw (35) with mem_ready low for 3 cycles in MEM_RD -> read held 4 cycles with i_or_d=1; WB_MEM gives mem_to_reg=1; retired increments once.
- bne (5) -> BRANCH cycle shows alu_op=11, branch_ne=1, pc_write_cond=1, pc_source=01; beq (4) shows alu_op=01, branch_ne=0.
- opcode=2 with ENABLE_JUMP=1 -> JUMP with pc_source=10, pc_write=1. Same opcode with ENABLE_JUMP=0, or opcode=63 -> trap=1, trap_cause=0, stays in TRAP until reset.
- TIMEOUT=4 with mem_ready held 0 in FETCH -> trap=1, trap_cause=1 after 4 wait cycles; a repeat run with mem_ready=1 on the 4th cycle -> no trap.
- CNT_W=3, eight addi (8) instructions -> retired wraps 7 -> 0. reset asserted mid-MEM_WR -> IDLE next cycle, retired=0.
